fsm3onehot_seq_tracker: RTL and testbench
=========================================

Name: fsm3onehot_seq_tracker

Overview:
Registered Moore stage that sits directly downstream of the one-hot next-state/output logic. It holds the 4-bit one-hot state register that the combinational stage reads, and it advances that register on qualified input bits. The stage also counts entries into the detect state and detects/recovers from non-one-hot register contents. A debug load port allows arbitrary (including illegal) states to be injected.

Parameters:
CNT_W, 8, width of saturating match counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
din_valid  in  1  din is consumed this cycle
din  in  1  serial input bit
ld_en  in  1  debug load of state register
ld_state  in  4  value loaded when ld_en=1 (may be non-one-hot)
clr  in  1  synchronous clear of match_cnt and illegal
state  out  4  registered state; bit0=A, bit1=B, bit2=C, bit3=D
dout  out  1  Moore output; 1 iff state==4'b1000
match_pulse  out  1  registered one-cycle pulse on each entry into D
match_cnt  out  CNT_W  saturating count of entries into D
illegal  out  1  sticky flag; set when a non-one-hot state is seen at a clock edge

Behaviour:
- Reset (reset=1 at clk edge) overrides all inputs: state=4'b0001, match_pulse=0, match_cnt=0, illegal=0. dout=0 as a consequence. Reset asserted mid-sequence discards progress immediately.
- Transition function, applied only when din_valid=1:
  - A: din=0 -> A; din=1 -> B.
  - B: din=0 -> C; din=1 -> B.
  - C: din=0 -> A; din=1 -> D.
  - D: din=0 -> C; din=1 -> B.
- din_valid=0: state holds. D is held too, so dout may stay 1 for several cycles.
- Update priority per edge, after reset:
  1. ld_en=1 -> state=ld_state. This ignores din_valid/din and does not count.
  2. Else, if the current state is not one-hot (zero or more than one bit set) -> state=4'b0001 regardless of din_valid, and illegal<=1. Recovery takes exactly 1 cycle.
  3. Else, if din_valid=1 -> state=next(state,din).
  4. Else hold.
- dout is combinational from the register: (state==4'b1000). Illegal values give dout=0, including those containing bit3.
- match_pulse is registered, =1 for the cycle immediately after an accepted transition C->D, and 0 otherwise. It coincides with the first cycle dout=1 after the transition. A ld_en load of 4'b1000 does not pulse. D never self-loops, so back-to-back pulses are impossible.
- match_cnt:
  - Increments by 1 on the same edge that sets match_pulse.
  - Saturates at 2^CNT_W-1, with no wrap.
  - clr=1 -> match_cnt=0. If clr coincides with a C->D entry, clr wins (cnt=0) but match_pulse still asserts.
- illegal:
  - Sticky until clr or reset.
  - If clr and a new illegal detection occur on the same edge, illegal=1 (set wins over clr).
  - clr does not affect state.
- Illegal detection uses the registered state, not ld_state. Loading an illegal value therefore flags on the following edge.

Test Plan:
- Reset, then din_valid=1 with din=1,0,1 -> state B, C, D. dout=1 and match_pulse=1 for 1 cycle on D entry; match_cnt=1.
- From D, din_valid=0 for 3 cycles, then din=0 -> state stays 4'b1000 with dout=1 for 3 cycles and match_pulse=0 throughout; then state=C and dout=0.
- CNT_W=2: repeat C->D entry 5 times -> match_cnt goes 1, 2, 3, 3, 3 and match_pulse fires 5 times. Then clr=1 -> match_cnt=0.
- ld_en=1, ld_state=4'b1010 -> next cycle state=1010 and dout=0. Following edge: state=0001 and illegal=1. illegal stays 1 until clr, then returns to 0.
- ld_en=1 with ld_state=0000 and din_valid=1 in the same cycle -> load wins (state=0000). Next edge recovers to A with illegal=1. match_cnt is unchanged.
- Mid-sequence at state C, assert reset together with din_valid=1, din=1 -> state=0001, match_pulse=0, match_cnt=0, illegal=0. No D entry is counted.

Source files
------------

// File: rtl/fsm3onehot_seq_tracker.sv
// rtl/fsm3onehot_seq_tracker.sv - one-hot sequence tracker with match counting and illegal-state recovery
module fsm3onehot_seq_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             ld_en,
    input  logic [3:0]       ld_state,
    input  logic             clr,
    output logic [3:0]       state,
    output logic             dout,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             illegal
);

    localparam logic [3:0] ST_A = 4'b0001;
    localparam logic [3:0] ST_B = 4'b0010;
    localparam logic [3:0] ST_C = 4'b0100;
    localparam logic [3:0] ST_D = 4'b1000;

    logic [3:0] state_next;
    logic [3:0] step_state;
    logic       legal;
    logic       enter_d;
    logic       set_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_A;
            match_pulse <= 1'b0;
            match_cnt   <= '0;
            illegal     <= 1'b0;
        end else begin
            state       <= state_next;
            match_pulse <= enter_d;
            if (clr)
                match_cnt <= '0;
            else if (enter_d && (match_cnt != {CNT_W{1'b1}}))
                match_cnt <= match_cnt + 1'b1;
            // A fresh detection outranks a clear on the same edge
            illegal <= set_illegal | (illegal & ~clr);
        end
    end

    always_comb begin
        step_state = state;
        legal      = 1'b1;
        case (state)
            ST_A:    step_state = din ? ST_B : ST_A;
            ST_B:    step_state = din ? ST_B : ST_C;
            ST_C:    step_state = din ? ST_D : ST_A;
            ST_D:    step_state = din ? ST_B : ST_C;
            default: legal      = 1'b0;
        endcase

        state_next = state;
        if (ld_en)
            state_next = ld_state;
        else if (!legal)
            state_next = ST_A;
        else if (din_valid)
            state_next = step_state;
    end

    always_comb begin
        dout        = (state == ST_D);
        set_illegal = !ld_en && !legal;
        enter_d     = !ld_en && legal && din_valid && din && (state == ST_C);
    end

endmodule

// File: tb/tb_fsm3onehot_seq_tracker.sv
// tb/tb_fsm3onehot_seq_tracker.sv - self-checking bench for fsm3onehot_seq_tracker
module tb_fsm3onehot_seq_tracker;

    localparam int CNT_W = 2;

    typedef struct {
        logic       rst;
        logic       dv;
        logic       d;
        logic       ld;
        logic [3:0] lds;
        logic       cl;
        logic [3:0] e_state;
        logic       e_dout;
        logic       e_pulse;
        logic [1:0] e_cnt;
        logic       e_ill;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic             ld_en = 1'b0;
    logic [3:0]       ld_state = 4'b0000;
    logic             clr = 1'b0;
    logic [3:0]       state;
    logic             dout;
    logic             match_pulse;
    logic [CNT_W-1:0] match_cnt;
    logic             illegal;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[27];
    vec_t sb_q[$];

    fsm3onehot_seq_tracker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .ld_en(ld_en), .ld_state(ld_state), .clr(clr),
        .state(state), .dout(dout), .match_pulse(match_pulse),
        .match_cnt(match_cnt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic dv, input logic d, input logic ld,
                                input logic [3:0] lds, input logic cl, input logic [3:0] es,
                                input logic eo, input logic ep, input logic [1:0] ec, input logic ei);
        vec_t v;
        v.rst = rst; v.dv = dv; v.d = d; v.ld = ld; v.lds = lds; v.cl = cl;
        v.e_state = es; v.e_dout = eo; v.e_pulse = ep; v.e_cnt = ec; v.e_ill = ei;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        vec_t e;
        @(negedge clk);
        reset = v.rst; din_valid = v.dv; din = v.d;
        ld_en = v.ld; ld_state = v.lds; clr = v.cl;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_vec++;
        if ({state, dout, match_pulse, match_cnt, illegal} !==
            {e.e_state, e.e_dout, e.e_pulse, e.e_cnt, e.e_ill}) begin
            n_bad++;
            $display("FAIL %s: got state=%b dout=%b pulse=%b cnt=%0d ill=%b, want state=%b dout=%b pulse=%b cnt=%0d ill=%b",
                     name, state, dout, match_pulse, match_cnt, illegal,
                     e.e_state, e.e_dout, e.e_pulse, e.e_cnt, e.e_ill);
        end
    endtask

    initial begin
        //               rst dv d  ld lds      cl  state   do pu cnt ill
        vecs[0]  = mk(1, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 4'b0000, 0, 4'b0010, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 1, 0, 4'b0000, 0, 4'b1000, 1, 1, 1, 0);
        vecs[4]  = mk(0, 0, 1, 0, 4'b0000, 0, 4'b1000, 1, 0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 4'b0000, 0, 4'b1000, 1, 0, 1, 0);
        vecs[6]  = mk(0, 0, 1, 0, 4'b0000, 0, 4'b1000, 1, 0, 1, 0);
        vecs[7]  = mk(0, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 0, 1, 0);
        vecs[8]  = mk(0, 1, 0, 0, 4'b0000, 0, 4'b0001, 0, 0, 1, 0);
        vecs[9]  = mk(0, 1, 0, 0, 4'b0000, 0, 4'b0001, 0, 0, 1, 0);
        vecs[10] = mk(0, 1, 1, 0, 4'b0000, 0, 4'b0010, 0, 0, 1, 0);
        vecs[11] = mk(0, 1, 1, 0, 4'b0000, 0, 4'b0010, 0, 0, 1, 0);
        vecs[12] = mk(0, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 0, 1, 0);
        vecs[13] = mk(0, 1, 1, 0, 4'b0000, 0, 4'b1000, 1, 1, 2, 0);
        vecs[14] = mk(0, 1, 1, 0, 4'b0000, 0, 4'b0010, 0, 0, 2, 0);
        vecs[15] = mk(0, 1, 1, 1, 4'b1010, 0, 4'b1010, 0, 0, 2, 0);
        vecs[16] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 0, 2, 1);
        vecs[17] = mk(0, 1, 1, 0, 4'b0000, 0, 4'b0010, 0, 0, 2, 1);
        vecs[18] = mk(0, 0, 0, 0, 4'b0000, 1, 4'b0010, 0, 0, 0, 0);
        vecs[19] = mk(0, 1, 1, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        vecs[20] = mk(0, 1, 1, 0, 4'b0000, 1, 4'b0001, 0, 0, 0, 1);
        vecs[21] = mk(0, 0, 0, 1, 4'b1000, 0, 4'b1000, 1, 0, 0, 1);
        vecs[22] = mk(0, 0, 0, 1, 4'b1001, 0, 4'b1001, 0, 0, 0, 1);
        vecs[23] = mk(0, 0, 0, 0, 4'b0000, 0, 4'b0001, 0, 0, 0, 1);
        vecs[24] = mk(0, 1, 1, 0, 4'b0000, 0, 4'b0010, 0, 0, 0, 1);
        vecs[25] = mk(0, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 0, 0, 1);
        vecs[26] = mk(1, 1, 1, 0, 4'b0000, 0, 4'b0001, 0, 0, 0, 0);

        for (int i = 0; i < 27; i++)
            apply(vecs[i], $sformatf("table[%0d]", i));

        // Repeated C->D entries drive the 2-bit counter into saturation
        apply(mk(0, 1, 1, 0, 4'b0000, 0, 4'b0010, 0, 0, 0, 0), "sat_to_b");
        apply(mk(0, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 0, 0, 0), "sat_to_c");
        for (int k = 0; k < 5; k++) begin
            logic [1:0] ec;
            ec = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
            apply(mk(0, 1, 1, 0, 4'b0000, 0, 4'b1000, 1, 1, ec, 0), $sformatf("sat_enter_d[%0d]", k));
            apply(mk(0, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 0, ec, 0), $sformatf("sat_back_c[%0d]", k));
        end
        apply(mk(0, 0, 0, 0, 4'b0000, 1, 4'b0100, 0, 0, 0, 0), "sat_clr");
        apply(mk(0, 1, 1, 0, 4'b0000, 0, 4'b1000, 1, 1, 1, 0), "enter_after_clr");
        apply(mk(0, 1, 0, 0, 4'b0000, 0, 4'b0100, 0, 0, 1, 0), "back_to_c");
        apply(mk(0, 1, 1, 0, 4'b0000, 1, 4'b1000, 1, 1, 0, 0), "clr_with_entry");
        apply(mk(0, 0, 0, 0, 4'b0000, 0, 4'b1000, 1, 0, 0, 0), "hold_d_no_pulse");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
